vga_timing: RTL and testbench

Generates 640x480@60 Hz VGA raster timing from the 100 MHz system clock. Drives the pixel coordinates `h_cnt`/`v_cnt` and the `valid` flag consumed by the pixel generator, the `hsync`/`vsync` pins, and frame-level strobes for the edit logic. It also produces a cursor blink flag used to highlight the editing cell.

---
 rtl/vga_if.sv | 22 ++
 rtl/vga_timing.sv | 153 +++++++++++++++
 tb/tb_vga_timing.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/vga_if.sv
// Raster timing bundle from vga_timing to the pixel generator and edit logic.
interface vga_if;
    logic       pix_tick;
    logic [9:0] h_cnt;
    logic [9:0] v_cnt;
    logic       valid;
    logic       hsync;
    logic       vsync;
    logic       frame_start;
    logic       vblank_start;
    logic       blink;

    modport master (
        output pix_tick, h_cnt, v_cnt, valid, hsync, vsync,
               frame_start, vblank_start, blink
    );

    modport slave (
        input  pix_tick, h_cnt, v_cnt, valid, hsync, vsync,
               frame_start, vblank_start, blink
    );
endinterface

// File: rtl/vga_timing.sv
// 640x480@60 VGA raster timing, pixel divider, frame strobes and cursor blink.
// Define VGA_SYNC_DELAY_EN to delay valid/hsync/vsync by one full pixel.
module vga_timing #(
    parameter int CLK_DIV      = 4,
    parameter int H_ACTIVE     = 640,
    parameter int H_FP         = 16,
    parameter int H_SYNC       = 96,
    parameter int H_BP         = 48,
    parameter int V_ACTIVE     = 480,
    parameter int V_FP         = 10,
    parameter int V_SYNC       = 2,
    parameter int V_BP         = 33,
    parameter int BLINK_FRAMES = 30
) (
    input  logic clk,
    input  logic rst,
    vga_if.master vga
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] V_PRE_VB = 10'(V_ACTIVE - 1);
    localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [5:0] F_LAST   = 6'(BLINK_FRAMES - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic [9:0]       h_cnt_q, h_cnt_d;
    logic [9:0]       v_cnt_q, v_cnt_d;
    logic [5:0]       fcnt_q, fcnt_d;
    logic             pix_tick_q, pix_tick_d;
    logic             valid_q, valid_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             frame_start_q, frame_start_d;
    logic             vblank_start_q, vblank_start_d;
    logic             blink_q, blink_d;
    logic             tick_s;
    logic             h_wrap_s;
    logic             valid_s, hsync_s, vsync_s;

    // Next-state: divider, raster counters, strobes, decode and blink phase.
    always_comb begin
        tick_s   = (div_q == DIV_LAST);
        h_wrap_s = (h_cnt_q == H_LAST);

        div_d          = tick_s ? '0 : div_q + DIV_W'(1);
        pix_tick_d     = tick_s;
        h_cnt_d        = h_cnt_q;
        v_cnt_d        = v_cnt_q;
        frame_start_d  = 1'b0;
        vblank_start_d = 1'b0;

        if (tick_s) begin
            if (h_wrap_s) begin
                h_cnt_d = 10'd0;
                if (v_cnt_q == V_LAST) begin
                    v_cnt_d = 10'd0;
                end else begin
                    v_cnt_d = v_cnt_q + 10'd1;
                end
            end else begin
                h_cnt_d = h_cnt_q + 10'd1;
            end
            frame_start_d  = h_wrap_s && (v_cnt_q == V_LAST);
            vblank_start_d = h_wrap_s && (v_cnt_q == V_PRE_VB);
        end else begin
            h_cnt_d = h_cnt_q;
        end

        valid_s = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
        hsync_s = !((h_cnt_q >= HS_FIRST) && (h_cnt_q <= HS_LAST));
        vsync_s = !((v_cnt_q >= VS_FIRST) && (v_cnt_q <= VS_LAST));

`ifdef VGA_SYNC_DELAY_EN
        // Sample the decode only at pixel boundaries so it trails the counters by a whole pixel.
        if (tick_s) begin
            valid_d = valid_s;
            hsync_d = hsync_s;
            vsync_d = vsync_s;
        end else begin
            valid_d = valid_q;
            hsync_d = hsync_q;
            vsync_d = vsync_q;
        end
`else
        valid_d = valid_s;
        hsync_d = hsync_s;
        vsync_d = vsync_s;
`endif

        fcnt_d  = fcnt_q;
        blink_d = blink_q;
        if (frame_start_q) begin
            if (fcnt_q == F_LAST) begin
                fcnt_d  = 6'd0;
                blink_d = ~blink_q;
            end else begin
                fcnt_d  = fcnt_q + 6'd1;
            end
        end else begin
            fcnt_d = fcnt_q;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q          <= '0;
            h_cnt_q        <= 10'd0;
            v_cnt_q        <= 10'd0;
            fcnt_q         <= 6'd0;
            pix_tick_q     <= 1'b0;
            valid_q        <= 1'b0;
            hsync_q        <= 1'b1;
            vsync_q        <= 1'b1;
            frame_start_q  <= 1'b0;
            vblank_start_q <= 1'b0;
            blink_q        <= 1'b0;
        end else begin
            div_q          <= div_d;
            h_cnt_q        <= h_cnt_d;
            v_cnt_q        <= v_cnt_d;
            fcnt_q         <= fcnt_d;
            pix_tick_q     <= pix_tick_d;
            valid_q        <= valid_d;
            hsync_q        <= hsync_d;
            vsync_q        <= vsync_d;
            frame_start_q  <= frame_start_d;
            vblank_start_q <= vblank_start_d;
            blink_q        <= blink_d;
        end
    end

    assign vga.pix_tick     = pix_tick_q;
    assign vga.h_cnt        = h_cnt_q;
    assign vga.v_cnt        = v_cnt_q;
    assign vga.valid        = valid_q;
    assign vga.hsync        = hsync_q;
    assign vga.vsync        = vsync_q;
    assign vga.frame_start  = frame_start_q;
    assign vga.vblank_start = vblank_start_q;
    assign vga.blink        = blink_q;

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing on a shrunken 16x11-pixel raster so whole frames and blink periods fit in a short run.
module tb_vga_timing;
    localparam int DIV = 4;
    localparam int HA = 8, HF = 2, HS = 3, HB = 3, HT = HA + HF + HS + HB;
    localparam int VA = 6, VF = 1, VS = 2, VB = 2, VT = VA + VF + VS + VB;
    localparam int BF = 2;
    localparam int FT = HT * VT;

    typedef struct packed {
        logic       pt;
        logic [9:0] h;
        logic [9:0] v;
        logic       vld;
        logic       hs;
        logic       vs;
        logic       fs;
        logic       vbs;
        logic       bl;
    } obs_t;

    typedef struct {
        int   t;
        obs_t e;
    } vec_t;

    localparam obs_t RST_OBS = {1'b0, 10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   t = 0;
    vec_t tbl[$];

    vga_if vif();

    vga_timing #(
        .CLK_DIV(DIV), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .BLINK_FRAMES(BF)
    ) dut (
        .clk(clk),
        .rst(rst),
        .vga(vif)
    );

    always #5 clk = ~clk;

    // Reference: everything follows from the number of clock edges since reset release.
    function automatic obs_t model(input int tt);
        obs_t o;
        int n, p, q, f;
        o     = RST_OBS;
        n     = tt / DIV;
        p     = n % FT;
        o.pt  = (tt > 0) && (tt % DIV == 0);
        o.h   = 10'(p % HT);
        o.v   = 10'(p / HT);
        o.fs  = o.pt && (p == 0);
        o.vbs = o.pt && (p % HT == 0) && (p / HT == VA);
`ifdef VGA_SYNC_DELAY_EN
        q = (n >= 1) ? (n - 1) % FT : -1;
`else
        q = (tt >= 1) ? ((tt - 1) / DIV) % FT : -1;
`endif
        if (q >= 0) begin
            o.vld = (q % HT < HA) && (q / HT < VA);
            o.hs  = !((q % HT >= HA + HF) && (q % HT < HA + HF + HS));
            o.vs  = !((q / HT >= VA + VF) && (q / HT < VA + VF + VS));
        end
        f    = (tt >= 1) ? (tt - 1) / (FT * DIV) : 0;
        o.bl = ((f / BF) % 2) == 1;
        return o;
    endfunction

    function automatic vec_t mk(input int tt, input int pt, input int h, input int v,
                                input int vld, input int hs, input int vs, input int fs, input int vbs);
        vec_t r;
        r.t     = tt;
        r.e.pt  = pt[0];
        r.e.h   = 10'(h);
        r.e.v   = 10'(v);
        r.e.vld = vld[0];
        r.e.hs  = hs[0];
        r.e.vs  = vs[0];
        r.e.fs  = fs[0];
        r.e.vbs = vbs[0];
        r.e.bl  = 1'b0;
        return r;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.pt  = vif.pix_tick;
        o.h   = vif.h_cnt;
        o.v   = vif.v_cnt;
        o.vld = vif.valid;
        o.hs  = vif.hsync;
        o.vs  = vif.vsync;
        o.fs  = vif.frame_start;
        o.vbs = vif.vblank_start;
        o.bl  = vif.blink;
        return o;
    endfunction

    task automatic compare(input string name, input obs_t exp);
        obs_t act;
        act = sample();
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 20)
                $display("FAIL %s t=%0d actual pt=%b h=%0d v=%0d vld=%b hs=%b vs=%b fs=%b vbs=%b bl=%b required pt=%b h=%0d v=%0d vld=%b hs=%b vs=%b fs=%b vbs=%b bl=%b",
                         name, t, act.pt, act.h, act.v, act.vld, act.hs, act.vs, act.fs, act.vbs, act.bl,
                         exp.pt, exp.h, exp.v, exp.vld, exp.hs, exp.vs, exp.fs, exp.vbs, exp.bl);
        end
    endtask

    task automatic compare_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 20) $display("FAIL %s t=%0d actual %b required %b", name, t, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (rst) t = 0;
        else     t = t + 1;
    endtask

    task automatic set_rst(input logic r);
        rst = r;
        #1;
        if (r) t = 0;
    endtask

    task automatic run_to(input int target);
        while (t < target) step();
    endtask

    initial begin
        // Hand-derived checkpoints on the 16x11 raster (hsync low h=10..12, vsync low v=7..8).
`ifdef VGA_SYNC_DELAY_EN
        tbl.push_back(mk(3,   0, 0, 0, 0, 1, 1, 0, 0));
        tbl.push_back(mk(4,   1, 1, 0, 1, 1, 1, 0, 0));
        tbl.push_back(mk(35,  0, 8, 0, 1, 1, 1, 0, 0));
        tbl.push_back(mk(36,  1, 9, 0, 0, 1, 1, 0, 0));
        tbl.push_back(mk(43,  0, 10, 0, 0, 1, 1, 0, 0));
        tbl.push_back(mk(44,  1, 11, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(55,  0, 13, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(56,  1, 14, 0, 0, 1, 1, 0, 0));
        tbl.push_back(mk(384, 1, 0, 6, 0, 1, 1, 0, 1));
        tbl.push_back(mk(385, 0, 0, 6, 0, 1, 1, 0, 0));
        tbl.push_back(mk(452, 1, 1, 7, 0, 1, 0, 0, 0));
        tbl.push_back(mk(704, 1, 0, 0, 0, 1, 1, 1, 0));
        tbl.push_back(mk(708, 1, 1, 0, 1, 1, 1, 0, 0));
`else
        tbl.push_back(mk(3,   0, 0, 0, 1, 1, 1, 0, 0));
        tbl.push_back(mk(4,   1, 1, 0, 1, 1, 1, 0, 0));
        tbl.push_back(mk(32,  1, 8, 0, 1, 1, 1, 0, 0));
        tbl.push_back(mk(33,  0, 8, 0, 0, 1, 1, 0, 0));
        tbl.push_back(mk(40,  1, 10, 0, 0, 1, 1, 0, 0));
        tbl.push_back(mk(41,  0, 10, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(52,  1, 13, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(53,  0, 13, 0, 0, 1, 1, 0, 0));
        tbl.push_back(mk(384, 1, 0, 6, 0, 1, 1, 0, 1));
        tbl.push_back(mk(385, 0, 0, 6, 0, 1, 1, 0, 0));
        tbl.push_back(mk(449, 0, 0, 7, 0, 1, 0, 0, 0));
        tbl.push_back(mk(704, 1, 0, 0, 0, 1, 1, 1, 0));
        tbl.push_back(mk(705, 0, 0, 0, 1, 1, 1, 0, 0));
`endif

        // Reset held from time zero.
        rst = 1'b1;
        repeat (3) step();
        compare("reset_hold", RST_OBS);
        set_rst(1'b0);

        foreach (tbl[i]) begin
            run_to(tbl[i].t);
            compare($sformatf("vec%0d", i), tbl[i].e);
        end

        // Blink toggles one clock after every second frame_start (frames at t=704*k).
        run_to(1408);
        compare_bit("blink_before_f2", vif.blink, 1'b0);
        step();
        compare_bit("blink_after_f2", vif.blink, 1'b1);
        run_to(2816);
        compare_bit("blink_before_f4", vif.blink, 1'b1);
        step();
        compare_bit("blink_after_f4", vif.blink, 1'b0);

        // Mid-frame reset: immediate asynchronous effect, held 10 clocks, then a clean restart.
        run_to(3000);
        set_rst(1'b1);
        compare("async_reset", RST_OBS);
        for (int i = 0; i < 10; i++) begin
            step();
            compare("reset_mid_frame", RST_OBS);
        end
        set_rst(1'b0);
        for (int i = 1; i <= 8; i++) begin
            step();
            compare_bit("tick_period", vif.pix_tick, (i % DIV) == 0);
            if (i == DIV) compare_bit("h_after_first_tick", vif.h_cnt == 10'd1, 1'b1);
        end

        // Random reset placement with every cycle checked against the reference.
        for (int seg = 0; seg < 8; seg++) begin
            int len;
            int hold;
            len  = (seg == 0) ? 3000 : int'($urandom_range(100, 3000));
            hold = int'($urandom_range(1, 12));
            for (int c = 0; c < len; c++) begin
                step();
                compare("random_run", model(t));
            end
            set_rst(1'b1);
            compare("random_async_reset", RST_OBS);
            for (int c = 0; c < hold; c++) begin
                step();
                compare("random_reset_hold", RST_OBS);
            end
            set_rst(1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
